spio_uart_tx_arbiter: RTL and testbench
=======================================

Name: spio_uart_tx_arbiter

Overview:
Shares one spio_uart_tx byte transmitter between NUM_PORTS independent byte-stream requesters.
- Frame-granular round-robin arbitration: a grant is held from the first byte until the byte flagged LAST.
- Each frame is prefixed with a header byte identifying the source port, so the far-end receiver can demultiplex.
- A stalled requester mid-frame is cut off after a timeout, and an abort byte is emitted.
- Sits between the byte producers and spio_uart_tx (DATA_OUT/VLD_OUT/RDY_IN connect to its DATA_IN/VLD_IN/RDY_OUT).

Parameters:
- NUM_PORTS, 4, number of requesters, 2..16.
- ID_BITS, 2, width of GRANT_OUT; must be at least $clog2(NUM_PORTS).
- HEADER_BASE, 8'hF0, header byte = HEADER_BASE + port index, modulo 256.
- ABORT_BYTE, 8'hFF, byte emitted when a frame is aborted.
- TIMEOUT, 256, consecutive idle cycles mid-frame before abort; 0 disables; max 65535.

Ports:
- CLK_IN  in  1  system clock.
- RESET_IN  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- DATA_IN  in  8*NUM_PORTS  byte per port; port i uses bits [8i+7:8i].
- VLD_IN  in  NUM_PORTS  per-port byte valid.
- LAST_IN  in  NUM_PORTS  per-port last byte of frame; qualified by VLD_IN.
- RDY_OUT  out  NUM_PORTS  per-port byte accepted.
- DATA_OUT  out  8  byte to UART TX.
- VLD_OUT  out  1  byte valid to UART TX.
- RDY_IN  in  1  UART TX ready.
- GRANT_OUT  out  ID_BITS  currently/last granted port.
- BUSY_OUT  out  1  high in any state except IDLE.
- ABORT_OUT  out  1  one-cycle pulse when the abort byte is accepted.

Behaviour:
- Reset (RESET_IN low, takes effect immediately):
  - state=IDLE, GRANT_OUT=0, last-grant pointer=NUM_PORTS-1 (port 0 has first priority), timeout counter=0.
  - VLD_OUT=0, DATA_OUT=8'h00, RDY_OUT=0, BUSY_OUT=0, ABORT_OUT=0.
- Reset mid-frame: the partial frame is dropped silently, with no abort byte. Requesters are responsible for restarting their frames.
- States: IDLE, HEADER, PAYLOAD, ABORT.
- IDLE:
  - VLD_OUT=0, RDY_OUT=0, DATA_OUT=0.
  - If any VLD_IN is high, select the first port with VLD high searching from (last_grant+1) mod NUM_PORTS upward with wrap. Register it into GRANT_OUT and the last-grant pointer, then go to HEADER.
  - Arbitration costs exactly one cycle; the inputs are sampled in IDLE only.
- HEADER:
  - VLD_OUT=1, DATA_OUT=HEADER_BASE+GRANT_OUT (8-bit wrap), RDY_OUT=0.
  - On RDY_IN, go to PAYLOAD; otherwise hold with DATA_OUT stable.
- PAYLOAD:
  - Combinational pass-through: DATA_OUT=DATA_IN[g], VLD_OUT=VLD_IN[g], RDY_OUT[g]=RDY_IN; all other RDY_OUT bits are 0.
  - VLD_IN[g]&RDY_IN&LAST_IN[g] goes to IDLE. This gives a minimum one IDLE cycle between frames, which is negligible at UART rates.
  - A frame may have 1..unbounded payload bytes. A header is always followed by at least one payload byte or by the abort byte.
- Timeout (active only when TIMEOUT≠0):
  - A 16-bit counter clears on entry to PAYLOAD and on any cycle with VLD_IN[g]=1.
  - Otherwise it increments while in PAYLOAD. When it reaches TIMEOUT, go to ABORT.
  - If VLD_IN[g] rises in the same cycle the count is reached, no abort occurs; the counter clears.
  - Stalls caused by RDY_IN low with VLD_IN[g] high never count.
- ABORT:
  - VLD_OUT=1, DATA_OUT=ABORT_BYTE, RDY_OUT=0.
  - On RDY_IN, pulse ABORT_OUT for one cycle and go to IDLE.
  - The aborted port loses its grant. Bytes it presents later start a new frame with a new header.
- Fairness: a port that has just completed or aborted a frame has lowest priority in the next arbitration.
- Unused grant encodings (NUM_PORTS < 2^ID_BITS) never occur.
- LAST_IN without VLD_IN is ignored. VLD_IN on ungranted ports never produces RDY_OUT.

Test Plan:
1. Idle: release reset, all VLD_IN=0 for 100 cycles → VLD_OUT=0, BUSY_OUT=0, RDY_OUT=0 throughout.
2. Single frame: port 1 sends 8'h10, 8'h11, 8'h12 (LAST on 8'h12), RDY_IN=1 → DATA_OUT accepted sequence F1, 10, 11, 12; GRANT_OUT=1; BUSY_OUT falls one cycle after the 8'h12 handshake.
3. Round-robin: from reset, all four ports hold one-byte frames A0..A3 continuously → accepted order F0 A0 F1 A1 F2 A2 F3 A3 F0 A0; no port is starved.
4. Backpressure: RDY_IN low for 10 cycles during HEADER and during PAYLOAD → VLD_OUT held 1, DATA_OUT stable, RDY_OUT[g]=0; no byte lost or duplicated; timeout counter stays 0.
5. Timeout: TIMEOUT=256; port 2 sends F2, 55, then VLD_IN[2]=0 → after exactly 256 idle cycles DATA_OUT=FF, ABORT_OUT pulses on acceptance, then a pending port 3 is granted (F3). Repeat with VLD_IN[2] returning at cycle 255 → no abort.
6. Reset mid-frame: assert RESET_IN low during PAYLOAD of port 3 → outputs idle immediately; after release, ports 0 and 3 both request and port 0 is granted first.

Source files
------------

// File: rtl/spio_uart_tx_arbiter.sv
// ============================================================================
// spio_uart_tx_arbiter
//
// Lets NUM_PORTS byte-stream producers share one spio_uart_tx byte
// transmitter. Arbitration is round-robin and frame-granular: once a port is
// granted, it keeps the grant until its byte flagged LAST is accepted. Every
// frame starts with a header byte (HEADER_BASE + port index) so the far-end
// receiver can demultiplex the streams. If the granted producer goes quiet
// mid-frame for TIMEOUT consecutive cycles, the frame is cut off with
// ABORT_BYTE and the port loses its grant.
//
// Ports:
//   CLK_IN     - system clock
//   RESET_IN   - asynchronous active-low reset
//   DATA_IN    - one byte per port, port i on bits [8i+7:8i]
//   VLD_IN     - per-port byte valid
//   LAST_IN    - per-port last-byte-of-frame flag, qualified by VLD_IN
//   RDY_OUT    - per-port byte accepted (only ever the granted port)
//   DATA_OUT   - byte to the UART transmitter
//   VLD_OUT    - byte valid to the UART transmitter
//   RDY_IN     - UART transmitter ready
//   GRANT_OUT  - currently / most recently granted port
//   BUSY_OUT   - high whenever a frame is in progress (any state but idle)
//   ABORT_OUT  - one-cycle pulse after the abort byte has been accepted
// ============================================================================
module spio_uart_tx_arbiter #(
    parameter int         NUM_PORTS   = 4,
    parameter int         ID_BITS     = 2,
    parameter logic [7:0] HEADER_BASE = 8'hF0,
    parameter logic [7:0] ABORT_BYTE  = 8'hFF,
    parameter int         TIMEOUT     = 256
) (
    input  logic                   CLK_IN,
    input  logic                   RESET_IN,
    input  logic [8*NUM_PORTS-1:0] DATA_IN,
    input  logic [NUM_PORTS-1:0]   VLD_IN,
    input  logic [NUM_PORTS-1:0]   LAST_IN,
    output logic [NUM_PORTS-1:0]   RDY_OUT,
    output logic [7:0]             DATA_OUT,
    output logic                   VLD_OUT,
    input  logic                   RDY_IN,
    output logic [ID_BITS-1:0]     GRANT_OUT,
    output logic                   BUSY_OUT,
    output logic                   ABORT_OUT
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_ABORT
    } state_t;

    // The abort fires on the idle cycle that brings the count up to TIMEOUT,
    // so the comparison is made against TIMEOUT-1 before incrementing.
    localparam bit          TIMEOUT_EN   = (TIMEOUT != 0);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t             state;
    logic [ID_BITS-1:0] grant;
    logic [ID_BITS-1:0] last_grant;
    logic [ID_BITS-1:0] next_grant;
    logic               any_req;
    logic [15:0]        idle_cnt;
    logic               abort_pulse;
    logic [7:0]         sel_data;
    logic               sel_vld;
    logic               sel_last;

    // Round-robin pick: scan from last_grant+1 upward with wrap. The loop
    // runs from the farthest candidate to the nearest so that the nearest
    // requesting port is the final (winning) assignment.
    always_comb begin
        next_grant = last_grant;
        any_req    = 1'b0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if ((i == (int'(last_grant) + k) % NUM_PORTS) && VLD_IN[i]) begin
                    next_grant = ID_BITS'(i);
                    any_req    = 1'b1;
                end
            end
        end
    end

    // Signals of the granted port, selected with a compare-per-port mux so
    // that unused grant encodings can never index outside the input vectors.
    always_comb begin
        sel_data = '0;
        sel_vld  = 1'b0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant == ID_BITS'(i)) begin
                sel_data = DATA_IN[8*i +: 8];
                sel_vld  = VLD_IN[i];
                sel_last = LAST_IN[i];
            end
        end
    end

    // Output decode. Payload is a straight combinational pass-through of the
    // granted port so that no extra latency sits in the UART byte path.
    always_comb begin
        DATA_OUT = '0;
        VLD_OUT  = 1'b0;
        RDY_OUT  = '0;
        unique case (state)
            ST_HEADER: begin
                VLD_OUT  = 1'b1;
                DATA_OUT = HEADER_BASE + 8'(grant);
            end
            ST_PAYLOAD: begin
                DATA_OUT = sel_data;
                VLD_OUT  = sel_vld;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (grant == ID_BITS'(i)) begin
                        RDY_OUT[i] = RDY_IN;
                    end
                end
            end
            ST_ABORT: begin
                VLD_OUT  = 1'b1;
                DATA_OUT = ABORT_BYTE;
            end
            default: begin
            end
        endcase
    end

    // Frame sequencer. Inputs are only arbitrated in idle, so a frame always
    // costs one idle cycle between its last byte and the next header. The
    // stall counter only runs while the granted producer has nothing valid;
    // transmitter backpressure with valid data held never counts.
    always_ff @(posedge CLK_IN or negedge RESET_IN) begin
        if (!RESET_IN) begin
            state       <= ST_IDLE;
            grant       <= '0;
            last_grant  <= ID_BITS'(NUM_PORTS - 1);
            idle_cnt    <= '0;
            abort_pulse <= 1'b0;
        end else begin
            abort_pulse <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant      <= next_grant;
                        last_grant <= next_grant;
                        state      <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (RDY_IN) begin
                        idle_cnt <= '0;
                        state    <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (sel_vld) begin
                        idle_cnt <= '0;
                        if (RDY_IN && sel_last) begin
                            state <= ST_IDLE;
                        end
                    end else if (TIMEOUT_EN) begin
                        idle_cnt <= idle_cnt + 16'd1;
                        if (idle_cnt == TIMEOUT_LAST) begin
                            state <= ST_ABORT;
                        end
                    end
                end
                ST_ABORT: begin
                    if (RDY_IN) begin
                        abort_pulse <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign GRANT_OUT = grant;
    assign BUSY_OUT  = (state != ST_IDLE);
    assign ABORT_OUT = abort_pulse;

endmodule

// File: tb/tb_spio_uart_tx_arbiter.sv
// ============================================================================
// tb_spio_uart_tx_arbiter
//
// Self-checking bench for spio_uart_tx_arbiter. Byte producers are modelled
// as per-port queues of frames; a cycle-level reference model built from the
// arbiter's frame rules (round robin, header, pass-through, stall timeout)
// predicts every output each cycle, and a per-port expected byte stream
// checks that no payload byte is lost, duplicated or reordered.
// ============================================================================
module tb_spio_uart_tx_arbiter;

    localparam int         NP  = 4;
    localparam int         TMO = 256;
    localparam logic [7:0] HB  = 8'hF0;
    localparam logic [7:0] AB  = 8'hFF;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [8*NP-1:0] data_in;
    logic [NP-1:0]   vld_in;
    logic [NP-1:0]   last_in;
    logic [NP-1:0]   rdy_out;
    logic [7:0]      data_out;
    logic            vld_out;
    logic            rdy_in;
    logic [1:0]      grant_out;
    logic            busy_out;
    logic            abort_out;

    // Free-running 100 MHz-style clock; the DUT acts on rising edges and the
    // bench drives and samples around the falling edge.
    always #5 clock = ~clock;

    spio_uart_tx_arbiter #(
        .NUM_PORTS  (NP),
        .ID_BITS    (2),
        .HEADER_BASE(HB),
        .ABORT_BYTE (AB),
        .TIMEOUT    (TMO)
    ) dut (
        .CLK_IN   (clock),
        .RESET_IN (reset_n),
        .DATA_IN  (data_in),
        .VLD_IN   (vld_in),
        .LAST_IN  (last_in),
        .RDY_OUT  (rdy_out),
        .DATA_OUT (data_out),
        .VLD_OUT  (vld_out),
        .RDY_IN   (rdy_in),
        .GRANT_OUT(grant_out),
        .BUSY_OUT (busy_out),
        .ABORT_OUT(abort_out)
    );

    typedef enum int {M_IDLE, M_HDR, M_PAY, M_ABT} mstate_t;

    int         tests = 0;
    int         fails = 0;

    logic [7:0] prod_data [NP][$];
    bit         prod_last [NP][$];
    logic [7:0] exp_data  [NP][$];
    bit         mid       [NP];
    int         stall_left[NP];
    int         stall_plan[NP];
    bit         gaps_en;
    int         rdy_mode;
    logic [7:0] accept_log[$];
    logic [7:0] exp_log[$];

    mstate_t    m_st;
    int         m_grant;
    int         m_last;
    int         m_idle;
    bit         m_pulse;

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_vec();
        return {15'd0, data_out, vld_out, rdy_out, grant_out, busy_out, abort_out};
    endfunction

    // Queue one byte for a producer and for the expected output stream.
    task automatic add_byte(input int p, input logic [7:0] d, input bit l);
        prod_data[p].push_back(d);
        prod_last[p].push_back(l);
        exp_data[p].push_back(d);
    endtask

    // Async reset: outputs must go idle immediately, even with inputs still
    // active, then all bench and model state is cleared before release.
    task automatic doReset();
        reset_n = 1'b0;
        #1;
        checkOutput("reset_outputs", obs_vec(), 32'd0);
        vld_in  = '0;
        last_in = '0;
        data_in = '0;
        rdy_in  = 1'b0;
        for (int i = 0; i < NP; i++) begin
            prod_data[i].delete();
            prod_last[i].delete();
            exp_data[i].delete();
            mid[i]        = 1'b0;
            stall_left[i] = 0;
            stall_plan[i] = 0;
        end
        accept_log.delete();
        m_st    = M_IDLE;
        m_grant = 0;
        m_last  = NP - 1;
        m_idle  = 0;
        m_pulse = 1'b0;
        repeat (2) @(negedge clock);
        #2;
        reset_n = 1'b1;
    endtask

    // Runs ncycles: drive producers and RDY_IN after the falling edge,
    // compare every output with the reference model, then advance the model
    // and the producers from the handshakes of that cycle.
    task automatic applyStimulus(input int ncycles);
        logic [31:0] exp_v;
        logic [7:0]  e_data;
        logic        e_vld;
        logic        e_busy;
        logic [3:0]  e_rdy;
        bit          go;
        bit          found;
        bit          l;
        int          idx;
        for (int c = 0; c < ncycles; c++) begin
            @(negedge clock);
            for (int i = 0; i < NP; i++) begin
                go = (prod_data[i].size() > 0) && (stall_left[i] == 0);
                if (go && gaps_en && mid[i] && ($urandom_range(0, 3) == 0)) go = 1'b0;
                if (stall_left[i] > 0) stall_left[i]--;
                if (go) begin
                    vld_in[i]         = 1'b1;
                    data_in[8*i +: 8] = prod_data[i][0];
                    last_in[i]        = prod_last[i][0];
                end else begin
                    vld_in[i]         = 1'b0;
                    data_in[8*i +: 8] = 8'($urandom);
                    last_in[i]        = 1'($urandom);
                end
            end
            rdy_in = (rdy_mode == 0) ? 1'b0 :
                     (rdy_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;

            case (m_st)
                M_HDR: begin
                    e_data = HB + 8'(m_grant); e_vld = 1'b1; e_rdy = '0; e_busy = 1'b1;
                end
                M_PAY: begin
                    e_data = data_in[8*m_grant +: 8];
                    e_vld  = vld_in[m_grant];
                    e_rdy  = 4'(rdy_in) << m_grant;
                    e_busy = 1'b1;
                end
                M_ABT: begin
                    e_data = AB; e_vld = 1'b1; e_rdy = '0; e_busy = 1'b1;
                end
                default: begin
                    e_data = 8'h00; e_vld = 1'b0; e_rdy = '0; e_busy = 1'b0;
                end
            endcase
            exp_v = {15'd0, e_data, e_vld, e_rdy, 2'(m_grant), e_busy, m_pulse};
            checkOutput("cycle_outputs", obs_vec(), exp_v);

            if (vld_out && rdy_in) accept_log.push_back(data_out);

            m_pulse = 1'b0;
            case (m_st)
                M_IDLE: begin
                    if (|vld_in) begin
                        found = 1'b0;
                        for (int k = 1; k <= NP; k++) begin
                            idx = (m_last + k) % NP;
                            if (!found && vld_in[idx]) begin
                                found   = 1'b1;
                                m_grant = idx;
                            end
                        end
                        m_last = m_grant;
                        m_st   = M_HDR;
                    end
                end
                M_HDR: begin
                    if (rdy_in) begin
                        m_idle = 0;
                        m_st   = M_PAY;
                    end
                end
                M_PAY: begin
                    if (vld_in[m_grant]) begin
                        m_idle = 0;
                        if (rdy_in) begin
                            checkOutput("payload_byte", 32'(data_out),
                                        (exp_data[m_grant].size() > 0) ?
                                        32'(exp_data[m_grant][0]) : 32'hFFFF_FFFF);
                            if (exp_data[m_grant].size() > 0) void'(exp_data[m_grant].pop_front());
                            if (last_in[m_grant]) m_st = M_IDLE;
                        end
                    end else begin
                        m_idle++;
                        if (m_idle == TMO) m_st = M_ABT;
                    end
                end
                M_ABT: begin
                    if (rdy_in) begin
                        m_pulse = 1'b1;
                        m_st    = M_IDLE;
                    end
                end
                default: m_st = M_IDLE;
            endcase

            for (int i = 0; i < NP; i++) begin
                if (rdy_out[i] && vld_in[i] && (prod_data[i].size() > 0)) begin
                    void'(prod_data[i].pop_front());
                    l = prod_last[i].pop_front();
                    if (l) begin
                        mid[i] = 1'b0;
                    end else begin
                        mid[i] = 1'b1;
                        if (stall_plan[i] > 0) begin
                            stall_left[i] = stall_plan[i];
                            stall_plan[i] = 0;
                        end
                    end
                end
            end
        end
    endtask

    // Runs until n bytes have been accepted, within a cycle budget.
    task automatic runUntilLog(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while ((accept_log.size() < n) && (c < budget)) begin
            applyStimulus(1);
            c++;
        end
        checkOutput({tag, "_reached"}, 32'(accept_log.size() >= n), 32'd1);
    endtask

    // Compares the accepted byte sequence against exp_log, entry by entry.
    task automatic checkLog(input string tag);
        for (int i = 0; i < exp_log.size(); i++) begin
            checkOutput($sformatf("%s_byte%0d", tag, i),
                        (i < accept_log.size()) ? 32'(accept_log[i]) : 32'hFFFF_FFFF,
                        32'(exp_log[i]));
        end
    endtask

    function automatic bit all_done();
        bit d;
        d = (m_st == M_IDLE);
        for (int i = 0; i < NP; i++) if (exp_data[i].size() != 0) d = 1'b0;
        return d;
    endfunction

    // Directed scenarios first, then randomized traffic rounds.
    initial begin
        int c;
        int nf;
        int len;
        reset_n  = 1'b1;
        vld_in   = '0;
        last_in  = '0;
        data_in  = '0;
        rdy_in   = 1'b0;
        gaps_en  = 1'b0;
        rdy_mode = 1;
        #2;
        doReset();

        // Idle: nothing requested for 100 cycles, random transmitter ready.
        rdy_mode = 2;
        applyStimulus(100);

        // Single three-byte frame from port 1.
        doReset();
        rdy_mode = 1;
        add_byte(1, 8'h10, 1'b0);
        add_byte(1, 8'h11, 1'b0);
        add_byte(1, 8'h12, 1'b1);
        runUntilLog(4, 50, "single");
        checkOutput("single_grant", 32'(grant_out), 32'd1);
        checkOutput("single_busy_last", 32'(busy_out), 32'd1);
        applyStimulus(1);
        checkOutput("single_busy_fall", 32'(busy_out), 32'd0);
        exp_log = '{8'hF1, 8'h10, 8'h11, 8'h12};
        checkLog("single");

        // Round robin: all ports hold one-byte frames continuously.
        doReset();
        for (int r = 0; r < 3; r++)
            for (int p = 0; p < NP; p++) add_byte(p, 8'hA0 + 8'(p), 1'b1);
        runUntilLog(10, 100, "rr");
        exp_log = '{8'hF0, 8'hA0, 8'hF1, 8'hA1, 8'hF2, 8'hA2, 8'hF3, 8'hA3, 8'hF0, 8'hA0};
        checkLog("rr");

        // Backpressure in header and in payload; a long payload stall with
        // valid held must never time out.
        doReset();
        add_byte(0, 8'h33, 1'b0);
        add_byte(0, 8'h34, 1'b1);
        rdy_mode = 0;
        applyStimulus(11);
        checkOutput("bp_header", 32'({vld_out, data_out, rdy_out}), 32'({1'b1, 8'hF0, 4'h0}));
        rdy_mode = 1;
        applyStimulus(1);
        rdy_mode = 0;
        applyStimulus(300);
        checkOutput("bp_payload", 32'({vld_out, data_out, rdy_out, abort_out}),
                    32'({1'b1, 8'h33, 4'h0, 1'b0}));
        rdy_mode = 1;
        runUntilLog(3, 20, "bp");
        exp_log = '{8'hF0, 8'h33, 8'h34};
        checkLog("bp");

        // Timeout: port 2 goes silent for exactly TMO cycles after its first
        // byte, port 3 waits; abort, then port 3, then port 2 restarts.
        doReset();
        add_byte(2, 8'h55, 1'b0);
        add_byte(2, 8'h56, 1'b1);
        stall_plan[2] = TMO;
        add_byte(3, 8'h99, 1'b1);
        runUntilLog(3, 400, "tmo");
        checkOutput("tmo_abort_pending", 32'(abort_out), 32'd0);
        applyStimulus(1);
        checkOutput("tmo_abort_pulse", 32'(abort_out), 32'd1);
        runUntilLog(7, 400, "tmo_tail");
        exp_log = '{8'hF2, 8'h55, 8'hFF, 8'hF3, 8'h99, 8'hF2, 8'h56};
        checkLog("tmo");

        // One cycle short of the timeout: the frame completes normally.
        doReset();
        add_byte(2, 8'h55, 1'b0);
        add_byte(2, 8'h56, 1'b1);
        stall_plan[2] = TMO - 1;
        add_byte(3, 8'h99, 1'b1);
        runUntilLog(5, 400, "tmo_edge");
        exp_log = '{8'hF2, 8'h55, 8'h56, 8'hF3, 8'h99};
        checkLog("tmo_edge");

        // Reset in the middle of a port 3 payload, then fresh arbitration.
        doReset();
        add_byte(3, 8'h30, 1'b0);
        add_byte(3, 8'h31, 1'b0);
        add_byte(3, 8'h32, 1'b1);
        applyStimulus(3);
        checkOutput("mid_in_payload", 32'({busy_out, grant_out}), 32'({1'b1, 2'd3}));
        doReset();
        add_byte(0, 8'h77, 1'b1);
        add_byte(3, 8'h88, 1'b1);
        runUntilLog(4, 50, "post_reset");
        exp_log = '{8'hF0, 8'h77, 8'hF3, 8'h88};
        checkLog("post_reset");

        // Randomized rounds: random frame counts, lengths, bytes, producer
        // gaps and transmitter ready, with no reset between rounds.
        doReset();
        gaps_en  = 1'b1;
        rdy_mode = 2;
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < NP; p++) begin
                nf = $urandom_range(0, 3);
                for (int f = 0; f < nf; f++) begin
                    len = $urandom_range(1, 5);
                    for (int b = 0; b < len; b++) add_byte(p, 8'($urandom), b == len - 1);
                end
            end
            c = 0;
            while (!all_done() && (c < 5000)) begin
                applyStimulus(1);
                c++;
            end
            checkOutput($sformatf("random_round%0d_drained", r), 32'(all_done()), 32'd1);
            applyStimulus(3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
